// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential AES-128 key expansion. A start strobe loads the
// cipher key, and the block then streams round keys 0..10, one per clock. The
// round-10 key is captured in last_key, and done stays high until the next start.
// Optional feature macro: AES_KEY_BANK_EN adds an 11-entry round-key bank with a
// combinational read port (rd_idx/rd_key).
module key_schedule_seq #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             key_valid,
    output logic             busy,
    output logic             done,
    output logic [KEY_W-1:0] last_key
`ifdef AES_KEY_BANK_EN
    ,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    // FIPS-197 forward S-box.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) with the AES polynomial; steps Rcon each round.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_t           state;
    state_t           state_next;
    logic [7:0]       rcon;
    logic             start_ok;
    logic             at_last;
    logic [31:0]      w3_rot;
    logic [31:0]      sub_t;
    logic [31:0]      n0, n1, n2, n3;
    logic [KEY_W-1:0] next_key;

    // start is honoured only outside an expansion in progress.
    assign start_ok = start && (state != EXPAND);
    assign at_last  = (round_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, regardless of block ordering.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_next = state;
        busy       = 1'b0;
        key_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = EXPAND;
            end
            EXPAND: begin
                busy      = 1'b1;
                key_valid = 1'b1;
                if (at_last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = EXPAND;
            end
            default: state_next = IDLE;
        endcase
    end

    // Key-expansion step: RotWord/SubWord on w3, mix in Rcon, then the XOR chain.
    assign w3_rot   = {round_key[23:0], round_key[31:24]};
    assign sub_t    = {SBOX[w3_rot[31:24]], SBOX[w3_rot[23:16]],
                       SBOX[w3_rot[15:8]],  SBOX[w3_rot[7:0]]} ^ {rcon, 24'h000000};
    assign n0       = round_key[127:96] ^ sub_t;
    assign n1       = round_key[95:64]  ^ n0;
    assign n2       = round_key[63:32]  ^ n1;
    assign n3       = round_key[31:0]   ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // Round-key datapath: load on accepted start, advance once per cycle while
    // expanding, capture key 10 into last_key as it is produced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_key <= '0;
            round_idx <= 4'd0;
            rcon      <= 8'h01;
            last_key  <= '0;
        end else if (start_ok) begin
            round_key <= key_in;
            round_idx <= 4'd0;
            rcon      <= 8'h01;
        end else if (busy && !at_last) begin
            round_key <= next_key;
            round_idx <= round_idx + 4'd1;
            rcon      <= xtime(rcon);
            if (round_idx == LAST_IDX - 4'd1) last_key <= next_key;
        end
    end

`ifdef AES_KEY_BANK_EN
    logic [KEY_W-1:0] bank [0:NUM_ROUNDS];

    // Bank capture: each streamed key is stored at its own round index.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: this storage array is deliberately cleared on reset so reads
        // after reset return zero; plain storage arrays normally skip reset.
        if (!rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) bank[i] <= '0;
        end else if (key_valid) begin
            bank[round_idx] <= round_key;
        end
    end

    assign rd_key = (rd_idx <= LAST_IDX) ? bank[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_key_schedule_seq.sv
// tb_key_schedule_seq: self-checking bench for key_schedule_seq. A word-level
// FIPS-197 key expansion (S-box derived from GF(2^8) inversion) and a timeline
// model of the streaming protocol predict every output on every cycle.
// Define AES_KEY_BANK_EN to exercise the key bank read port.
module tb_key_schedule_seq;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;
    logic [127:0] last_key;
`ifdef AES_KEY_BANK_EN
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_key;
`endif

    always #5 clk = ~clk;

    key_schedule_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done),
        .last_key  (last_key)
`ifdef AES_KEY_BANK_EN
        ,
        .rd_idx    (rd_idx),
        .rd_key    (rd_key)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 word-oriented expansion; returns round key r.
    function automatic logic [127:0] sched_key(input logic [127:0] k, input int r);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]],
                        sbox_m[temp[15:8]],  sbox_m[temp[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Timeline model: age = cycles since the accepted start (-1: nothing since reset).
    int           age = -1;
    logic [127:0] m_sched [0:10];
    logic [127:0] m_bank  [0:10];
    logic [127:0] m_last = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            age    <= -1;
            m_last <= '0;
            for (int i = 0; i < 11; i++) m_bank[i] <= '0;
        end else begin
            if (start && (age < 1 || age >= 12)) begin
                age <= 1;
                for (int r = 0; r < 11; r++) m_sched[r] <= sched_key(key_in, r);
            end else if (age >= 1 && age < 12) begin
                age <= age + 1;
                if (age == 11) m_last <= m_sched[10];
            end
            if (age >= 1 && age <= 11) m_bank[age-1] <= m_sched[age-1];
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [127:0] e_key;
    logic [3:0]   e_idx;
    logic         e_valid, e_busy, e_done;
    logic         prev_valid = 1'b0;
    logic         prev_done  = 1'b0;
    logic [3:0]   prev_idx   = 4'd0;
    int           pulses     = 0;

    always @(negedge clk) begin
        if (!rst || age < 1) begin
            e_key = '0; e_idx = 4'd0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else if (age <= 11) begin
            e_key = m_sched[age-1]; e_idx = 4'(age - 1); e_valid = 1'b1; e_busy = 1'b1; e_done = 1'b0;
        end else begin
            e_key = m_sched[10]; e_idx = 4'd10; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b1;
        end
        check("round_key", round_key, e_key);
        check("round_idx", round_idx, e_idx);
        check("key_valid", key_valid, e_valid);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        if (!rst || age != 11) check("last_key", last_key, m_last);
`ifdef AES_KEY_BANK_EN
        check("rd_key", rd_key, (rst && rd_idx <= 4'd10) ? m_bank[rd_idx] : 128'h0);
`endif
        // Protocol properties.
        check("valid_and_done", key_valid & done, 1'b0);
        check("busy_and_done", busy & done, 1'b0);
        if (key_valid) begin
            if (prev_valid) check("idx_step", round_idx, prev_idx + 4'd1);
            else            check("idx_first", round_idx, 4'd0);
            pulses = prev_valid ? pulses + 1 : 1;
        end
        if (done && !prev_done) check("pulse_count", pulses, 11);
        prev_valid = key_valid;
        prev_idx   = round_idx;
        prev_done  = done;
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [127:0] k);
        @(posedge clk); #1;
        start  = 1'b1;
        key_in = k;
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic goto(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        build_sbox();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Pin the reference model itself.
        check("model_sbox_00", sbox_m[8'h00], 8'h63);
        check("model_sbox_53", sbox_m[8'h53], 8'hed);
        check("model_fips_r1", sched_key(FIPS_KEY, 1), FIPS_R1);
        check("model_fips_r10", sched_key(FIPS_KEY, 10), FIPS_R10);
        check("model_zero_r1", sched_key(128'h0, 1), ZERO_R1);
        check("model_zero_r10", sched_key(128'h0, 10), ZERO_R10);

        // FIPS key: literal pins at T+2, T+11, T+12.
        do_start(FIPS_KEY);
        goto(1);
        check("fips_t2_idx", round_idx, 4'd1);
        check("fips_t2_key", round_key, FIPS_R1);
        goto(9);
        check("fips_t11_key", round_key, FIPS_R10);
        goto(1);
        check("fips_t12_done", done, 1'b1);
        check("fips_t12_last", last_key, FIPS_R10);
`ifdef AES_KEY_BANK_EN
        rd_idx = 4'd0;  #1 check("bank_idx0", rd_key, FIPS_KEY);
        rd_idx = 4'd10; #1 check("bank_idx10", rd_key, FIPS_R10);
        rd_idx = 4'd12; #1 check("bank_idx12", rd_key, 128'h0);
        rd_idx = 4'd0;
`endif

        // Reset mid-expansion at T+5, then restart.
        do_start(FIPS_KEY);
        goto(4);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_key", round_key, 128'h0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_valid", key_valid, 1'b0);
        check("rst_mid_last", last_key, 128'h0);
`ifdef AES_KEY_BANK_EN
        check("rst_mid_bank", rd_key, 128'h0);
`endif
        @(posedge clk); #1 rst = 1'b1;
        do_start(FIPS_KEY);
        goto(11);
        check("restart_last", last_key, FIPS_R10);

        // All-zero key.
        do_start(128'h0);
        goto(1);
        check("zero_t2_key", round_key, ZERO_R1);
        goto(9);
        check("zero_t11_key", round_key, ZERO_R10);
        goto(1);

        // Starts at T+3 and T+7 during busy are ignored.
        do_start(FIPS_KEY);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1 start = 1'b0;
        goto(3);
        check("ignore_t11_key", round_key, FIPS_R10);
        goto(1);
        check("ignore_t12_done", done, 1'b1);

        // Start in DONE with the zero key.
        do_start(128'h0);
        @(negedge clk);
        check("redo_t1_done", done, 1'b0);
        goto(9);
        check("redo_t10_last_old", last_key, FIPS_R10);
        goto(2);
        check("redo_t12_last_new", last_key, ZERO_R10);

        // Randomized traffic: random starts (many ignored), occasional resets.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 79) == 0) rst = 1'b0;
            start  = ($urandom_range(0, 5) == 0);
            key_in = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_KEY_BANK_EN
            rd_idx = 4'($urandom_range(0, 15));
`endif
        end
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
